ntt_seq_ctrl: RTL



---
 rtl/ntt_seq_pkg.sv | 45 ++++
 rtl/seq_drain_cnt.sv | 29 ++
 rtl/ntt_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ntt_seq_pkg.sv
// Shared constants and types for the NTT phase sequencer and the address/enable generator.
package ntt_seq_pkg;

  localparam logic [2:0] ConfIdle       = 3'b000;
  localparam logic [2:0] ConfRadix2     = 3'b001;
  localparam logic [2:0] ConfRadix4     = 3'b010;
  localparam logic [2:0] ConfDoneRadix2 = 3'b011;
  localparam logic [2:0] ConfDoneRadix4 = 3'b100;

  localparam logic [1:0] ModeFull = 2'b00;
  localparam logic [1:0] ModeR2   = 2'b01;
  localparam logic [1:0] ModeR4   = 2'b10;
  localparam logic [1:0] ModeRsvd = 2'b11;

  localparam logic [1:0] DoneFlagR2 = 2'b01;
  localparam logic [1:0] DoneFlagR4 = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StR2,
    StR2Drain,
    StR4,
    StR4Drain,
    StFin
  } seq_state_e;

  // Bits needed to hold v-1, never less than one.
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic logic [2:0] state_conf(seq_state_e s);
    logic [2:0] c;
    c = ConfIdle;
    unique case (s)
      StR2:      c = ConfRadix2;
      StR2Drain: c = ConfDoneRadix2;
      StR4:      c = ConfRadix4;
      StR4Drain: c = ConfDoneRadix4;
      default:   c = ConfIdle;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_drain_cnt.sv
// Loadable down-counter that saturates at zero; used for drain holds and the watchdog.
module seq_drain_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  output logic [Width-1:0] value,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Phase sequencer for the mixed-radix NTT: RADIX2 -> DONE_RADIX2 -> RADIX4 -> DONE_RADIX4.
// Define NTT_SEQ_TIMEOUT_EN to add a RUN-phase watchdog that flags err and returns to idle.
module ntt_seq_ctrl
  import ntt_seq_pkg::*;
#(
  parameter int unsigned DRAIN_R2 = 8,
  parameter int unsigned DRAIN_R4 = 14,
  parameter int unsigned TIMEOUT  = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  input  logic [1:0] done_flag,
  output logic [2:0] conf,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned DrainMax = (DRAIN_R2 > DRAIN_R4) ? DRAIN_R2 : DRAIN_R4;
  localparam int unsigned CntW     = clog2_min1(DrainMax);
  localparam logic [CntW-1:0] R2Load = CntW'(DRAIN_R2 - 1);
  localparam logic [CntW-1:0] R4Load = CntW'(DRAIN_R4 - 1);

  seq_state_e      state_q, state_d;
  logic [1:0]      mode_q;
  logic            accept, rsvd_start, timeout_hit, wd_expire;
  logic            drain_load, drain_dec, drain_zero;
  logic [CntW-1:0] drain_load_value, unused_drain_value;

  seq_drain_cnt #(
    .Width(CntW)
  ) u_drain_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (drain_load),
    .load_value(drain_load_value),
    .dec       (drain_dec),
    .value     (unused_drain_value),
    .zero      (drain_zero)
  );

`ifdef NTT_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = clog2_min1(TIMEOUT);
  logic           wd_load, wd_dec, wd_zero, in_run_q, in_run_d;
  logic [WdW-1:0] unused_wd_value;

  assign in_run_q = (state_q == StR2) || (state_q == StR4);
  assign in_run_d = (state_d == StR2) || (state_d == StR4);
  // Reload on every entry into a RUN phase, including R2_DRAIN -> R4.
  assign wd_load   = in_run_d && (state_d != state_q);
  assign wd_dec    = in_run_q;
  assign wd_expire = in_run_q && wd_zero;

  seq_drain_cnt #(
    .Width(WdW)
  ) u_wd_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (wd_load),
    .load_value(WdW'(TIMEOUT - 1)),
    .dec       (wd_dec),
    .value     (unused_wd_value),
    .zero      (wd_zero)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_expire      = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    rsvd_start       = 1'b0;
    timeout_hit      = 1'b0;
    drain_load       = 1'b0;
    drain_dec        = 1'b0;
    drain_load_value = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (mode == ModeRsvd) begin
            rsvd_start = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = (mode == ModeR4) ? StR4 : StR2;
          end
        end
      end
      StR2: begin
        if (done_flag == DoneFlagR2) begin
          state_d          = StR2Drain;
          drain_load       = 1'b1;
          drain_load_value = R2Load;
        end else if (wd_expire) begin
          state_d     = StIdle;
          timeout_hit = 1'b1;
        end
      end
      StR2Drain: begin
        if (drain_zero) state_d = (mode_q == ModeFull) ? StR4 : StFin;
        else            drain_dec = 1'b1;
      end
      StR4: begin
        if (done_flag == DoneFlagR4) begin
          state_d          = StR4Drain;
          drain_load       = 1'b1;
          drain_load_value = R4Load;
        end else if (wd_expire) begin
          state_d     = StIdle;
          timeout_hit = 1'b1;
        end
      end
      StR4Drain: begin
        if (drain_zero) state_d = StFin;
        else            drain_dec = 1'b1;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides any done_flag, drain expiry or timeout seen this cycle.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      timeout_hit = 1'b0;
      drain_load  = 1'b0;
      drain_dec   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mode_q  <= ModeFull;
      conf    <= ConfIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      conf    <= state_conf(state_d);
      busy    <= (state_d != StIdle);
      done    <= (state_d == StFin);
      if (accept) begin
        mode_q <= mode;
        err    <= 1'b0;
      end else if (rsvd_start || timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule
